// File: rtl/weight_loader.sv
// Write-side master for the 8x8 weight register file: assembles header/payload
// byte frames into single-cycle write or clear strobes and tracks frame/error status.
module weight_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       err_clr,
    output logic       updateWeight,
    output logic       rf_reset,
    output logic [2:0] Addr1,
    output logic [2:0] Addr2,
    output logic [7:0] Data1,
    output logic [7:0] Data2,
    output logic       busy,
    output logic [7:0] frame_count,
    output logic       err_addr,
    output logic       err_timeout
);

    typedef enum logic [2:0] {
        IDLE,
        GET_A,
        GET_B,
        COMMIT,
        CLEAR
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  addr_a_q, addr_a_d;
    logic [2:0]  addr_b_q, addr_b_d;
    logic [7:0]  data_a_q, data_a_d;
    logic        single_q, single_d;
    logic        discard_q, discard_d;
    logic [15:0] idle_cnt_q, idle_cnt_d;
    logic        upd_q, upd_d;
    logic        rfr_q, rfr_d;
    logic [2:0]  addr1_q, addr1_d;
    logic [2:0]  addr2_q, addr2_d;
    logic [7:0]  data1_q, data1_d;
    logic [7:0]  data2_q, data2_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        err_addr_q, err_addr_d;
    logic        err_to_q, err_to_d;

    logic        ready;
    logic        xfer;
    logic        set_err_addr;
    logic        set_err_to;
    logic        timeout_hit;

    assign ready       = (state_q == IDLE) || (state_q == GET_A) || (state_q == GET_B);
    assign xfer        = in_valid && ready;
    assign timeout_hit = ({1'b0, idle_cnt_q} + 17'd1) >= 17'(TIMEOUT_CYCLES);

    always_comb begin
        state_d      = state_q;
        addr_a_d     = addr_a_q;
        addr_b_d     = addr_b_q;
        data_a_d     = data_a_q;
        single_d     = single_q;
        discard_d    = discard_q;
        idle_cnt_d   = '0;
        upd_d        = 1'b0;
        rfr_d        = 1'b0;
        addr1_d      = addr1_q;
        addr2_d      = addr2_q;
        data1_d      = data1_q;
        data2_d      = data2_q;
        frame_cnt_d  = frame_cnt_q;
        set_err_addr = 1'b0;
        set_err_to   = 1'b0;

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    addr_a_d = in_data[5:3];
                    addr_b_d = in_data[2:0];
                    case (in_data[7:6])
                        2'b01: begin
                            state_d      = GET_A;
                            single_d     = 1'b0;
                            discard_d    = (in_data[5:3] == in_data[2:0]);
                            set_err_addr = (in_data[5:3] == in_data[2:0]);
                        end
                        2'b10: begin
                            state_d     = CLEAR;
                            upd_d       = 1'b1;
                            rfr_d       = 1'b1;
                            frame_cnt_d = frame_cnt_q + 8'd1;
                        end
                        2'b11: begin
                            state_d   = GET_A;
                            single_d  = 1'b1;
                            discard_d = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            GET_A: begin
                if (xfer) begin
                    data_a_d = in_data;
                    if (single_q) begin
                        state_d     = COMMIT;
                        upd_d       = 1'b1;
                        addr1_d     = addr_a_q;
                        addr2_d     = addr_a_q;
                        data1_d     = in_data;
                        data2_d     = in_data;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end else begin
                        state_d = GET_B;
                    end
                end else if (timeout_hit) begin
                    state_d    = IDLE;
                    set_err_to = 1'b1;
                end else begin
                    idle_cnt_d = idle_cnt_q + 16'd1;
                end
            end
            GET_B: begin
                if (xfer) begin
                    // a conflicting pair still swallows its payload, then drops it
                    if (discard_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d     = COMMIT;
                        upd_d       = 1'b1;
                        addr1_d     = addr_a_q;
                        addr2_d     = addr_b_q;
                        data1_d     = data_a_q;
                        data2_d     = in_data;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end else if (timeout_hit) begin
                    state_d    = IDLE;
                    set_err_to = 1'b1;
                end else begin
                    idle_cnt_d = idle_cnt_q + 16'd1;
                end
            end
            COMMIT:  state_d = IDLE;
            CLEAR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        err_addr_d = (err_addr_q && !err_clr) || set_err_addr;
        err_to_d   = (err_to_q && !err_clr) || set_err_to;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            data_a_q    <= '0;
            single_q    <= 1'b0;
            discard_q   <= 1'b0;
            idle_cnt_q  <= '0;
            upd_q       <= 1'b0;
            rfr_q       <= 1'b0;
            addr1_q     <= '0;
            addr2_q     <= '0;
            data1_q     <= '0;
            data2_q     <= '0;
            frame_cnt_q <= '0;
            err_addr_q  <= 1'b0;
            err_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_a_q    <= addr_a_d;
            addr_b_q    <= addr_b_d;
            data_a_q    <= data_a_d;
            single_q    <= single_d;
            discard_q   <= discard_d;
            idle_cnt_q  <= idle_cnt_d;
            upd_q       <= upd_d;
            rfr_q       <= rfr_d;
            addr1_q     <= addr1_d;
            addr2_q     <= addr2_d;
            data1_q     <= data1_d;
            data2_q     <= data2_d;
            frame_cnt_q <= frame_cnt_d;
            err_addr_q  <= err_addr_d;
            err_to_q    <= err_to_d;
        end
    end

    assign in_ready     = ready;
    assign busy         = (state_q != IDLE);
    assign updateWeight = upd_q;
    assign rf_reset     = rfr_q;
    assign Addr1        = addr1_q;
    assign Addr2        = addr2_q;
    assign Data1        = data1_q;
    assign Data2        = data2_q;
    assign frame_count  = frame_cnt_q;
    assign err_addr     = err_addr_q;
    assign err_timeout  = err_to_q;

endmodule

// File: tb/tb_weight_loader.sv
// Bench for weight_loader: directed frame table, corner sequences and random
// traffic, all checked every cycle against a frame-level reference model.
module tb_weight_loader;

    localparam int unsigned TO = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       err_clr = 1'b0;
    logic       in_ready, updateWeight, rf_reset, busy, err_addr, err_timeout;
    logic [2:0] Addr1, Addr2;
    logic [7:0] Data1, Data2, frame_count;

    int unsigned tests = 0;
    int unsigned fails = 0;
    bit          chk_en = 1'b0;
    logic [22:0] strobes[$];

    weight_loader #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .err_clr(err_clr), .updateWeight(updateWeight),
        .rf_reset(rf_reset), .Addr1(Addr1), .Addr2(Addr2), .Data1(Data1),
        .Data2(Data2), .busy(busy), .frame_count(frame_count),
        .err_addr(err_addr), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Reference model: frame progress as "payload bytes still owed" plus a
    // strobe marker for the cycle after a frame completes.
    int         m_need = 0;
    int         m_stb = 0;
    int         m_idle = 0;
    bit         m_conf = 1'b0;
    logic [7:0] m_hdr = '0;
    logic [7:0] m_bytes[$];
    logic [2:0] m_a1 = '0, m_a2 = '0;
    logic [7:0] m_d1 = '0, m_d2 = '0, m_fc = '0;
    logic       m_ea = 1'b0, m_et = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model
        bit new_ea, new_et;
        new_ea = 1'b0;
        new_et = 1'b0;
        if (!rst_n) begin
            m_need = 0; m_stb = 0; m_idle = 0; m_conf = 1'b0;
            m_bytes.delete();
            m_a1 = '0; m_a2 = '0; m_d1 = '0; m_d2 = '0; m_fc = '0;
            m_ea = 1'b0; m_et = 1'b0;
        end else begin
            if (m_stb != 0) begin
                m_stb = 0;
            end else if (m_need == 0) begin
                if (in_valid) begin
                    m_hdr = in_data;
                    m_bytes.delete();
                    m_idle = 0;
                    case (in_data[7:6])
                        2'b01: begin
                            m_need = 2;
                            m_conf = (in_data[5:3] == in_data[2:0]);
                            new_ea = m_conf;
                        end
                        2'b10: begin m_stb = 2; m_fc = m_fc + 8'd1; end
                        2'b11: begin m_need = 1; m_conf = 1'b0; end
                        default: ;
                    endcase
                end
            end else if (in_valid) begin
                m_bytes.push_back(in_data);
                m_need = m_need - 1;
                m_idle = 0;
                if (m_need == 0 && !m_conf) begin
                    m_stb = 1;
                    m_fc = m_fc + 8'd1;
                    m_a1 = m_hdr[5:3];
                    m_d1 = m_bytes[0];
                    if (m_hdr[7:6] == 2'b11) begin
                        m_a2 = m_hdr[5:3];
                        m_d2 = m_bytes[0];
                    end else begin
                        m_a2 = m_hdr[2:0];
                        m_d2 = m_bytes[1];
                    end
                end
            end else begin
                m_idle = m_idle + 1;
                if (m_idle >= int'(TO)) begin
                    new_et = 1'b1;
                    m_need = 0;
                    m_idle = 0;
                end
            end
            m_ea = (m_ea && !err_clr) || new_ea;
            m_et = (m_et && !err_clr) || new_et;
        end
    end

    always @(negedge clk) begin
        logic [35:0] act, exp;
        if (chk_en) begin
            exp = {m_stb == 0, (m_stb != 0) || (m_need != 0), m_stb != 0, m_stb == 2,
                   m_a1, m_a2, m_d1, m_d2, m_fc, m_ea, m_et};
            act = {in_ready, busy, updateWeight, rf_reset, Addr1, Addr2, Data1, Data2,
                   frame_count, err_addr, err_timeout};
            tests++;
            if (act !== exp) begin
                fails++;
                $display("FAIL cycle t=%0t got=%h expected=%h", $time, act, exp);
            end
            if (updateWeight === 1'b1) strobes.push_back({rf_reset, Addr1, Data1, Addr2, Data2});
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            tests++;
            fails++;
            $display("FAIL send_wait got=in_ready_low expected=ready_within_50");
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    typedef struct {
        int          n;
        logic [7:0]  b0, b1, b2;
        int          ns;
        logic [22:0] stb;
        logic [7:0]  fc;
        logic        ea;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int rf_cnt;
        int pct;
        vecs[0] = '{3, 8'h51, 8'h22, 8'h33, 1, {1'b0, 3'd2, 8'h22, 3'd1, 8'h33}, 8'd1, 1'b0};
        vecs[1] = '{2, 8'hE8, 8'h7F, 8'h00, 1, {1'b0, 3'd5, 8'h7F, 3'd5, 8'h7F}, 8'd2, 1'b0};
        vecs[2] = '{1, 8'h80, 8'h00, 8'h00, 1, {1'b1, 3'd5, 8'h7F, 3'd5, 8'h7F}, 8'd3, 1'b0};
        vecs[3] = '{3, 8'h5B, 8'h11, 8'h22, 0, 23'd0, 8'd3, 1'b1};
        vecs[4] = '{1, 8'h00, 8'h00, 8'h00, 0, 23'd0, 8'd3, 1'b1};
        vecs[5] = '{2, 8'hC0, 8'hAA, 8'h00, 1, {1'b0, 3'd0, 8'hAA, 3'd0, 8'hAA}, 8'd4, 1'b1};

        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_upd", {31'd0, updateWeight}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_fc", {24'd0, frame_count}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            strobes.delete();
            send(vecs[i].b0);
            if (vecs[i].n > 1) send(vecs[i].b1);
            if (vecs[i].n > 2) send(vecs[i].b2);
            idle(3);
            chk($sformatf("vec%0d_nstb", i), strobes.size(), vecs[i].ns);
            if (vecs[i].ns == 1 && strobes.size() > 0)
                chk($sformatf("vec%0d_stb", i), {9'd0, strobes[0]}, {9'd0, vecs[i].stb});
            chk($sformatf("vec%0d_fc", i), {24'd0, frame_count}, {24'd0, vecs[i].fc});
            chk($sformatf("vec%0d_ea", i), {31'd0, err_addr}, {31'd0, vecs[i].ea});
        end

        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        chk("errclr_ea", {31'd0, err_addr}, 32'd0);

        strobes.delete();
        send(8'h40);
        send(8'h01);
        idle(5);
        chk("to_flag", {31'd0, err_timeout}, 32'd1);
        chk("to_busy", {31'd0, busy}, 32'd0);
        chk("to_nstb", strobes.size(), 32'd0);
        send(8'h51); send(8'h22); send(8'h33);
        idle(3);
        chk("to_after_nstb", strobes.size(), 32'd1);
        if (strobes.size() > 0)
            chk("to_after_stb", {9'd0, strobes[0]}, {9'd0, 1'b0, 3'd2, 8'h22, 3'd1, 8'h33});
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        chk("errclr_to", {31'd0, err_timeout}, 32'd0);

        send(8'h51); send(8'h22);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_fc", {24'd0, frame_count}, 32'd0);
        chk("arst_addr_data", {8'd0, Addr1, Addr2, Data1, Data2}, 32'd0);
        chk("arst_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        strobes.delete();
        send(8'h33);
        idle(3);
        chk("arst_nop_nstb", strobes.size(), 32'd0);
        chk("arst_nop_fc", {24'd0, frame_count}, 32'd0);

        strobes.delete();
        for (int i = 0; i < 256; i++) send(8'h80);
        idle(3);
        chk("wrap_nstb", strobes.size(), 32'd256);
        chk("wrap_fc", {24'd0, frame_count}, 32'd0);
        rf_cnt = 0;
        foreach (strobes[k]) if (strobes[k][22]) rf_cnt++;
        chk("wrap_rfr", rf_cnt, 32'd256);

        pct = 70;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) pct = (i % 600 == 0) ? 95 : ((i % 400 == 0) ? 30 : 70);
            @(negedge clk);
            in_valid = ($urandom_range(0, 99) < pct);
            in_data  = 8'($urandom);
            err_clr  = ($urandom_range(0, 19) == 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        err_clr  = 1'b0;
        idle(8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/weight_loader.md
Name: weight_loader

Overview:
- Write-side master for the pedometer weight register file.
- Accepts a byte-stream command channel (valid/ready) from the host/training logic, assembles address/data frames and issues single-cycle write or clear strobes on the register file's dual write port: updateWeight, reset, Addr1/Addr2, Data1/Data2.
- Sits between the host byte interface and the 8x8 weight register file.
- Also reports frame and error status.

Parameters:
- TIMEOUT_CYCLES, 255, idle cycles allowed between payload bytes before a partial frame is aborted (1..65535).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_data  input  8  command/payload byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader can accept a byte this cycle.
- err_clr  input  1  clears sticky error flags.
- updateWeight  output  1  register-file write enable, one-cycle pulse.
- rf_reset  output  1  register-file clear request; only asserted together with updateWeight.
- Addr1  output  3  write address, port 1.
- Addr2  output  3  write address, port 2.
- Data1  output  8  write data, port 1.
- Data2  output  8  write data, port 2.
- busy  output  1  a frame is in progress (state != IDLE).
- frame_count  output  8  completed frames (writes and clears), wraps 255->0.
- err_addr  output  1  sticky: pair write rejected because addrA == addrB.
- err_timeout  output  1  sticky: partial frame aborted by timeout.

Behaviour:
- Handshake: a byte transfers on a rising edge where in_valid && in_ready. in_ready = 1 in IDLE, GET_A and GET_B; 0 in COMMIT and CLEAR.
- Header byte (accepted in IDLE) has three fields:
  - [7:6] = op.
  - [5:3] = addrA.
  - [2:0] = addrB.
- Opcodes:
  - op 00: NOP. Header consumed, no state change, no count.
  - op 01: PAIR. Next two bytes are dataA then dataB. IDLE -> GET_A -> GET_B -> COMMIT.
  - op 10: CLEAR. No payload. IDLE -> CLEAR.
  - op 11: SINGLE. Next byte is dataA. IDLE -> GET_A -> COMMIT. Both ports are driven with addrA/dataA, so there is no write conflict.
- PAIR with addrA == addrB is detected at header accept:
  - set err_addr;
  - consume and discard both payload bytes;
  - return to IDLE with no updateWeight pulse and no frame_count increment.
- COMMIT (one cycle): updateWeight = 1, rf_reset = 0.
  - Addr1 = addrA, Data1 = dataA, Addr2 = addrB, Data2 = dataB (SINGLE: addrA/dataA on both ports).
  - Addr/Data are registered and held stable after commit until the next commit.
  - frame_count increments. Next state IDLE.
- CLEAR (one cycle): updateWeight = 1 and rf_reset = 1. Addr/Data keep their previous values. frame_count increments. Next state IDLE.
- Latency: the strobe is asserted in the cycle immediately after the last byte of the frame is accepted. The next header can be accepted in the cycle after the strobe, so the minimum frame period is bytes + 1 cycles.
- updateWeight and rf_reset are registered outputs and are 0 in every state other than COMMIT/CLEAR.
- Timeout:
  - A 16-bit idle counter runs in GET_A/GET_B. It clears on every accepted byte and increments on cycles with no transfer.
  - When it reaches TIMEOUT_CYCLES: set err_timeout, discard the frame, go to IDLE, no strobe.
  - The counter is held at 0 in IDLE.
- err_clr: clears both sticky flags on the next edge. If err_clr and a new error event occur in the same cycle, the error set wins.
- frame_count wraps 8'hFF -> 8'h00 with no flag.
- Reset (async, active-low), applied at any time including mid-frame:
  - state = IDLE; in_ready = 1 once reset is released.
  - updateWeight = 0, rf_reset = 0.
  - Addr1 = Addr2 = 0, Data1 = Data2 = 0.
  - frame_count = 0, err_addr = 0, err_timeout = 0, busy = 0.
  - Any partial frame is lost and no strobe is issued.
- busy = 1 in GET_A, GET_B, COMMIT and CLEAR.

Test Plan:
- Pair write:
  - Stimulus: bytes 0x51, 0x22, 0x33 back-to-back.
  - Response: one cycle after 0x33 is accepted, updateWeight = 1 for exactly 1 cycle with Addr1 = 2, Data1 = 0x22, Addr2 = 1, Data2 = 0x33; frame_count = 1.
- Single and clear:
  - Stimulus: 0xE8, 0x7F, then 0x80.
  - Response: commit with Addr1 = Addr2 = 5 and Data1 = Data2 = 0x7F; then one cycle with updateWeight = 1 and rf_reset = 1; frame_count = 2.
- Address conflict:
  - Stimulus: 0x5B (addrA = addrB = 3), 0x11, 0x22.
  - Response: no updateWeight pulse; err_addr = 1; frame_count unchanged.
  - Follow-up: err_clr pulse -> err_addr = 0.
- Timeout (TIMEOUT_CYCLES = 4):
  - Stimulus: 0x40, 0x01, then in_valid low for 4 cycles.
  - Response: err_timeout = 1, state returns to IDLE, no strobe.
  - Follow-up: a following 0x51/0x22/0x33 commits normally.
- Reset mid-frame:
  - Stimulus: assert reset after 0x51 and 0x22 have been accepted.
  - Response: all outputs at their reset values immediately (asynchronous).
  - Follow-up: after release, byte 0x33 alone is treated as a header (op 00 NOP) and produces no write.
- Wrap and back-pressure:
  - Stimulus: 256 CLEAR frames with in_valid held high continuously.
  - Response: in_ready = 0 on each CLEAR cycle; frame_count returns to 0x00; exactly 256 strobes.
